// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-entry holding register, optional parity and 1 or 2 stop bits.
// Back-to-back frames reload straight from the final stop-bit edge with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic [7:0] data,
    input  logic valid,
    output logic ready,
    output logic tx,
    output logic busy,
    output logic done
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state, state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] hold, shift, shift_next;
    logic hold_full, par, tick, last_data, last_stop, load;

    assign tick = baud_cnt == BW'(CLKS_PER_BIT - 1);
    assign last_data = bit_cnt == 3'(DATA_BITS - 1);
    assign last_stop = bit_cnt == 3'(STOP_BITS - 1);
    assign load = hold_full && (state == IDLE || (state == STOP && tick && last_stop));
    assign ready = ~hold_full;
    assign busy = state != IDLE;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = hold_full ? START : IDLE;
            START: state_next = tick ? DATA : START;
            DATA: state_next = (tick && last_data) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
            PARITY: state_next = tick ? STOP : PARITY;
            STOP: state_next = (tick && last_stop) ? (hold_full ? START : IDLE) : STOP;
            default: state_next = IDLE;
        endcase
        shift_next = load ? hold : (state == DATA && tick) ? shift >> 1 : shift;
    end

    // tx is registered, so it is derived from the next state and next shift value
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold_full <= 1'b0;
            baud_cnt <= '0;
            bit_cnt <= '0;
            tx <= 1'b1;
            done <= 1'b0;
        end else begin
            state <= state_next;
            baud_cnt <= (state == IDLE || tick) ? '0 : baud_cnt + 1'b1;
            bit_cnt <= !tick ? bit_cnt : (state_next != state) ? '0 : bit_cnt + 1'b1;
            done <= state == STOP && tick && last_stop;
            tx <= state_next == START ? 1'b0 :
                  state_next == DATA ? shift_next[0] :
                  state_next == PARITY ? par : 1'b1;
            if (valid && ready)
                hold_full <= 1'b1;
            else if (load)
                hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (valid && ready)
            hold <= data;
        shift <= shift_next;
        if (load)
            par <= ^(hold[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx configurations (8N1, 8E1, 8O2) at 4 clocks per bit, each checked
// by a scoreboard monitor that decodes frames from tx against bytes queued by its driver.
module tb_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    int checks = 0;
    int errors = 0;
    int nfin = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[cfg%0d]: got %0h expected %0h", nm, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int PE = (g == 0) ? 0 : 1;
        localparam int PO = (g == 2) ? 1 : 0;
        localparam int SB = (g == 2) ? 2 : 1;

        logic rst_i, valid_i, ready_i, tx_i, busy_i, done_i;
        logic [7:0] data_i;
        logic [8:0] q[$];

        uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)) dut (
            .clk(clk), .reset(rst_i), .data(data_i), .valid(valid_i),
            .ready(ready_i), .tx(tx_i), .busy(busy_i), .done(done_i)
        );

        // Called at a negedge; returns at the negedge after the transfer edge.
        task automatic send(input logic [7:0] b, input bit push, input bit ab, input bit jit);
            int n = 0;
            valid_i = 1'b1;
            data_i = b;
            while (ready_i !== 1'b1 && n < 200) begin
                data_i = jit ? 8'($urandom) : b;
                @(negedge clk);
                n++;
            end
            data_i = b;
            if (n >= 200)
                chk("ready_timeout", g, 32'(ready_i), 1);
            else if (push)
                q.push_back({ab, b});
            @(negedge clk);
            valid_i = 1'b0;
            data_i = 8'($urandom);
        endtask

        task automatic wait_idle();
            int n = 0;
            while ((q.size() != 0 || busy_i !== 1'b0) && n < 1000) begin
                @(negedge clk);
                n++;
            end
            chk("drain", g, 32'(n < 1000), 1);
        endtask

        initial begin : drv
            int n;
            rst_i = 1'b1;
            valid_i = 1'b0;
            data_i = 8'h00;
            repeat (5) @(negedge clk);
            chk("rst_tx", g, tx_i, 1);
            chk("rst_ready", g, ready_i, 1);
            chk("rst_busy", g, busy_i, 0);
            chk("rst_done", g, done_i, 0);
            rst_i = 1'b0;
            send(8'hA5, 1, 0, 0);
            chk("lat_hold", g, tx_i, 1);
            @(negedge clk);
            chk("lat_start", g, tx_i, 0);
            wait_idle();
            send(8'h00, 1, 0, 0);
            send(8'hFF, 1, 0, 0);
            n = 0;
            while (done_i !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("no_gap_tx", g, tx_i, 0);
            chk("no_gap_busy", g, busy_i, 1);
            wait_idle();
            send(8'h07, 1, 0, 0);
            send(8'h3C, 1, 0, 0);
            wait_idle();
            send(8'h11, 1, 0, 0);
            send(8'h22, 1, 0, 0);
            send(8'h5A, 1, 0, 1);
            wait_idle();
            // abort: 0x96 in flight, 0x33 queued; reset lands inside data bit 3
            send(8'h96, 1, 1, 0);
            send(8'h33, 0, 0, 0);
            repeat (16) @(negedge clk);
            rst_i = 1'b1;
            @(negedge clk);
            chk("abort_tx", g, tx_i, 1);
            chk("abort_ready", g, ready_i, 1);
            chk("abort_busy", g, busy_i, 0);
            chk("abort_done", g, done_i, 0);
            rst_i = 1'b0;
            repeat (60) @(negedge clk);
            chk("post_abort_tx", g, tx_i, 1);
            chk("post_abort_busy", g, busy_i, 0);
            chk("post_abort_q", g, q.size(), 0);
            nfin++;
        end

        initial begin : mon
            logic [8:0] e;
            logic [11:0] bits;
            int fl;
            bit aborted, ok;
            @(negedge clk);
            forever begin
                if (rst_i || tx_i !== 1'b0) begin
                    @(negedge clk);
                    if (!rst_i && tx_i === 1'b1)
                        chk("idle_done", g, done_i, 0);
                end else begin
                    chk("frame_expected", g, 32'(q.size() != 0), 1);
                    e = (q.size() != 0) ? q.pop_front() : 9'h000;
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++)
                        bits[1 + i] = e[i];
                    if (PE != 0)
                        bits[9] = (^e[7:0]) ^ (PO != 0);
                    fl = (9 + PE + SB) * CPB;
                    aborted = 1'b0;
                    ok = 1'b1;
                    for (int c = 0; c < fl && !aborted; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst_i)
                            aborted = 1'b1;
                        else begin
                            if (c % CPB == 0) ok = 1'b1;
                            ok &= (tx_i === bits[c / CPB]) && (busy_i === 1'b1) && (c == 0 || done_i === 1'b0);
                            if (c % CPB == CPB - 1)
                                chk($sformatf("byte%02h_bit%0d", e[7:0], c / CPB), g, 32'(ok), 1);
                        end
                    end
                    chk("abort_flag", g, 32'(aborted), 32'(e[8]));
                    if (!aborted) begin
                        @(negedge clk);
                        chk("done_pulse", g, done_i, 1);
                    end
                end
            end
        end
    end

    initial begin
        int n = 0;
        while (nfin < 3 && n < 30000) begin
            @(posedge clk);
            n++;
        end
        chk("all_finished", 0, nfin, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. It is the transmit-side counterpart to the design's UART receiver and produces 8N1-style frames (parity optional) on a single serial line. A single-entry holding register with a valid/ready handshake lets upstream logic queue the next byte while the current frame shifts out. Frames sent back-to-back have no idle gap between them. The bit timing comes from an internal divider, so no external baud clock is needed.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
DATA_BITS, 8, data bits per frame, sent LSB first; legal range 5..8.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, selects the parity sense when PARITY_EN=1: 0 = even, 1 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
data  input  8  byte to send; bits above DATA_BITS-1 are ignored.
valid  input  1  upstream asserts when data is valid.
ready  output  1  holding register is empty; a transfer occurs on a clk edge with valid && ready.
tx  output  1  serial line output, registered; idle level is 1.
busy  output  1  1 whenever the FSM is not in IDLE.
done  output  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset (sampled on posedge clk): tx=1, ready=1, busy=0, done=0, FSM=IDLE, holding register empty, baud counter=0, bit counter=0. The reset value of the data registers is don't-care.
- Reset mid-frame: at the reset edge, tx returns to 1 and the frame in flight is abandoned. Any queued byte is discarded. No done pulse is generated.
- Handshake:
  - A transfer happens at any edge where valid && ready; data is captured into the holding register and hold_full is set.
  - ready = ~hold_full.
  - valid while ready=0 is ignored; upstream must hold data and valid until the transfer.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If hold_full at an edge: load the shift register from the holding register, clear hold_full, and go to START.
  - tx=0 becomes visible after that edge. Latency: a byte accepted at edge k drives tx low from edge k+1 onward.
- Baud counter: counts 0..CLKS_PER_BIT-1 inside each bit and wraps to 0 on a bit boundary. Each bit lasts exactly CLKS_PER_BIT cycles.
- START: tx=0 for one bit time, then DATA with bit counter=0.
- DATA:
  - tx = shift register bit 0; the register shifts right at each bit boundary.
  - The bit counter increments per bit.
  - After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR of the DATA_BITS sent, inverted when PARITY_ODD=1. Lasts one bit time, then STOP.
- STOP: tx=1 for STOP_BITS bit times.
- End of frame, at the boundary edge of the final stop bit:
  - done=1 for exactly one cycle after that edge.
  - If hold_full: load, clear hold_full, go directly to START. tx falls at the same edge, with zero idle cycles between frames.
  - Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from tx falling edge to the next possible tx falling edge.
- Simultaneous events:
  - The holding register is read and a new transfer is requested on the same edge: no transfer occurs, because ready was 0. ready rises after that edge.
  - A transfer during an active frame queues exactly one byte and does not disturb tx.
- busy = (state != IDLE). It stays 1 across back-to-back frames.
- data is sampled only at the transfer edge; later changes have no effect on tx.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0, reset for 5 cycles, then send data=0xA5 with a one-cycle valid pulse -> tx=1 during reset. From the edge after the transfer, tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. done pulses once 40 cycles after tx falls. busy=1 for those 40 cycles.
2. Back-to-back: hold valid high with 0x00 then 0xFF -> the second transfer occurs during frame 1. tx goes straight from frame 1's stop bit to frame 2's start bit with no idle cycle. ready=0 from the second transfer until frame 2 loads.
3. PARITY_EN=1, PARITY_ODD=0, send 0xA5 -> parity bit 0. With PARITY_ODD=1 -> parity bit 1. With 0x07 and even parity -> parity bit 1. Frame length is 44 cycles at CLKS_PER_BIT=4.
4. STOP_BITS=2, send 0x3C -> the stop level lasts 8 cycles. done pulses once, at the end of the second stop bit.
5. Assert reset during DATA bit 3 with a byte queued -> tx=1 after the reset edge, ready=1, busy=0, no done pulse. After reset releases, tx stays 1 and no frame is sent until a new valid arrives.
6. Hold valid=1 while ready=0 and change data every cycle -> only the value present at the ready=1 transfer edge is transmitted.
